// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH stages of WIDTH bits with per-stage valids,
// valid/ready handshake at both ends, bubble collapsing, synchronous flush and
// a registered occupancy count.
module pipe_reg_elastic #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] d_nxt [DEPTH];
  logic [OW-1:0]    cnt_nxt;

  // Ready chain from the output back to the input; an empty stage is always
  // ready, which is what lets bubbles close while the output is stalled.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = !v[DEPTH-1] | out_ready;
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      rdy[DEPTH-2-i] = !v[DEPTH-2-i] | rdy[DEPTH-1-i];
    end
  end

  // Next-state valids/data per stage, plus population count of next valids.
  // Flush clears valids only; data registers keep their contents.
  always_comb begin
    logic             vin;
    logic [WIDTH-1:0] din;
    v_nxt   = v;
    cnt_nxt = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      d_nxt[k] = d[k];
      if (k == 0) begin
        vin = in_valid & !flush;
        din = in_data;
      end else begin
        vin = v[k-1];
        din = d[k-1];
      end
      if (rdy[k]) begin
        v_nxt[k] = vin;
        if (vin && !flush) d_nxt[k] = din;
      end
      if (flush) v_nxt[k] = 1'b0;
      cnt_nxt = cnt_nxt + OW'(v_nxt[k]);
    end
  end

  // Stage registers and occupancy; reset overrides flush and handshakes.
  always_ff @(posedge clk) begin
    if (res) begin
      v         <= '0;
      occupancy <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) d[k] <= '0;
    end else begin
      v         <= v_nxt;
      occupancy <= cnt_nxt;
      for (int unsigned k = 0; k < DEPTH; k++) d[k] <= d_nxt[k];
    end
  end

  assign in_ready  = rdy[0] & !flush;
  assign out_valid = v[DEPTH-1] & !flush;
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic: a vector table on a DEPTH=2 instance
// plus hand sequences for streaming, backpressure, bubble collapse and
// simultaneous transfer on DEPTH=2/3/4 instances sharing the same inputs.
module tb_pipe_reg_elastic;

  logic       clk = 1'b0;
  logic       res, in_valid, out_ready, flush;
  logic [3:0] in_data;

  logic       ir2, ov2, ir3, ov3, ir4, ov4;
  logic [3:0] od2, od3, od4;
  logic [1:0] occ2, occ3;
  logic [2:0] occ4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_reg_elastic #(.WIDTH(4), .DEPTH(2)) u2 (
    .clk(clk), .res(res), .in_data(in_data), .in_valid(in_valid), .in_ready(ir2),
    .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .flush(flush), .occupancy(occ2));
  pipe_reg_elastic #(.WIDTH(4), .DEPTH(3)) u3 (
    .clk(clk), .res(res), .in_data(in_data), .in_valid(in_valid), .in_ready(ir3),
    .out_data(od3), .out_valid(ov3), .out_ready(out_ready), .flush(flush), .occupancy(occ3));
  pipe_reg_elastic #(.WIDTH(4), .DEPTH(4)) u4 (
    .clk(clk), .res(res), .in_data(in_data), .in_valid(in_valid), .in_ready(ir4),
    .out_data(od4), .out_valid(ov4), .out_ready(out_ready), .flush(flush), .occupancy(occ4));

  typedef struct {
    logic       res, iv;
    logic [3:0] id;
    logic       ordy, fl, chk, e_ir, e_ov;
    logic [3:0] e_od;
    logic [1:0] e_occ;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [3:0] id,
                       input logic ordy, input logic fl);
    @(negedge clk);
    res = r; in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int acc;
    int got;
    logic [3:0] exp_q [$];

    res = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

    //          res iv  id    ordy fl  chk ir  ov  od    occ
    tbl[0]  = '{1,  1,  4'hF, 0,   0,  0,  1,  0,  4'h0, 0};
    tbl[1]  = '{1,  1,  4'hF, 0,   0,  1,  1,  0,  4'h0, 0};
    tbl[2]  = '{0,  1,  4'h3, 0,   0,  1,  1,  0,  4'h0, 0};
    tbl[3]  = '{0,  0,  4'h0, 0,   0,  1,  1,  0,  4'h0, 1};
    tbl[4]  = '{0,  1,  4'h5, 0,   0,  1,  1,  1,  4'h3, 1};
    tbl[5]  = '{0,  1,  4'h6, 0,   0,  1,  0,  1,  4'h3, 2};
    tbl[6]  = '{0,  1,  4'h6, 1,   0,  1,  1,  1,  4'h3, 2};
    tbl[7]  = '{0,  1,  4'h7, 1,   0,  1,  1,  1,  4'h5, 2};
    tbl[8]  = '{0,  1,  4'h8, 1,   1,  1,  0,  0,  4'h6, 2};
    tbl[9]  = '{0,  1,  4'h9, 0,   0,  1,  1,  0,  4'h6, 0};
    tbl[10] = '{0,  0,  4'h0, 1,   0,  1,  1,  0,  4'h6, 1};
    tbl[11] = '{0,  0,  4'h0, 1,   0,  1,  1,  1,  4'h9, 1};
    tbl[12] = '{0,  0,  4'h0, 0,   0,  1,  1,  0,  4'h9, 0};
    tbl[13] = '{1,  1,  4'hA, 1,   1,  1,  0,  0,  4'h9, 0};
    tbl[14] = '{0,  0,  4'h0, 0,   0,  1,  1,  0,  4'h0, 0};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].res, tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d.in_ready", i),  32'(ir2),  32'(tbl[i].e_ir));
        check($sformatf("tbl%0d.out_valid", i), 32'(ov2),  32'(tbl[i].e_ov));
        check($sformatf("tbl%0d.out_data", i),  32'(od2),  32'(tbl[i].e_od));
        check($sformatf("tbl%0d.occupancy", i), 32'(occ2), 32'(tbl[i].e_occ));
      end
    end

    // Streaming through DEPTH=3: item i accepted in cycle i-1, seen in cycle i+2.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      int eocc [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
      drive(1'b0, c < 4, 4'(c + 1), 1'b1, 1'b0);
      check($sformatf("stream%0d.in_ready", c),  32'(ir3), 32'd1);
      check($sformatf("stream%0d.out_valid", c), 32'(ov3), 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check($sformatf("stream%0d.out_data", c), 32'(od3), 32'(c - 2));
      check($sformatf("stream%0d.occupancy", c), 32'(occ3), 32'(eocc[c]));
    end

    // Backpressure on DEPTH=3: only three of five offered items get in.
    do_reset();
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, acc < 5, 4'(10 + acc), 1'b0, 1'b0);
      if (ir3 && acc < 5) acc++;
    end
    drive(1'b0, 1'b1, 4'(10 + acc), 1'b0, 1'b0);
    check("bp.accepted",  32'(acc),  32'd3);
    check("bp.in_ready",  32'(ir3),  32'd0);
    check("bp.occupancy", 32'(occ3), 32'd3);
    check("bp.out_valid", 32'(ov3),  32'd1);
    check("bp.out_data",  32'(od3),  32'd10);
    exp_q = '{4'd10, 4'd11, 4'd12};
    got = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      if (ov3) begin
        if (got < 3) check($sformatf("bp.drain%0d", got), 32'(od3), 32'(exp_q[got]));
        got++;
      end
    end
    check("bp.drained", 32'(got), 32'd3);

    // Bubble collapse on DEPTH=4: A, idle, B with the output stalled.
    do_reset();
    drive(1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'hB, 1'b0, 1'b0);
    check("bub.in_ready_b", 32'(ir4), 32'd1);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    check("bub.occupancy", 32'(occ4), 32'd2);
    check("bub.in_ready",  32'(ir4),  32'd1);
    check("bub.out_valid", 32'(ov4),  32'd1);
    check("bub.out_data",  32'(od4),  32'hA);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    check("bub.next_valid", 32'(ov4), 32'd1);
    check("bub.next_data",  32'(od4), 32'hB);

    // Simultaneous in/out transfer with DEPTH=2 full.
    do_reset();
    drive(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b1, 4'(c + 3), 1'b1, 1'b0);
      check($sformatf("sim%0d.in_ready", c),  32'(ir2),  32'd1);
      check($sformatf("sim%0d.out_valid", c), 32'(ov2),  32'd1);
      check($sformatf("sim%0d.out_data", c),  32'(od2),  32'(c + 1));
      check($sformatf("sim%0d.occupancy", c), 32'(occ2), 32'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
